// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: saturating cycle/stall/flush/retire counters
// gated by an IDLE/RUN/DONE run controller, with a registered readout mux.
module pipe_perf_monitor #(
  parameter int CNT_W   = 32,
  parameter int LIMIT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic               bubble_i,
  input  logic               jump_i,
  input  logic               branch_i,
  input  logic               flush1_i,
  input  logic               flush2_i,
  input  logic               retire_i,
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic [1:0]         sel_i,
  output logic [CNT_W-1:0]   rdata_o,
  output logic               done_o,
  output logic [3:0]         sat_o,
  output logic [1:0]         state_o
);

  localparam int CMP_W = (CNT_W > LIMIT_W) ? CNT_W : LIMIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Counter slots follow the readout select: 0 cycle, 1 stall, 2 flush, 3 retired.
  logic [3:0][CNT_W-1:0] cnt;
  logic [3:0]            event_hit;
  logic [3:0]            inc;
  logic [3:0]            sat_hit;
  logic                  count_en;
  logic [CNT_W-1:0]      cycle_new;
  logic                  limit_hit;

  always_comb begin
    count_en  = start_i && (state != DONE);
    event_hit = {retire_i,
                 flush1_i | flush2_i,
                 bubble_i & ~jump_i & ~branch_i,
                 1'b1};
    inc       = '0;
    sat_hit   = '0;
    for (int k = 0; k < 4; k++) begin
      inc[k]     = count_en && event_hit[k] && (cnt[k] != CNT_MAX);
      sat_hit[k] = count_en && event_hit[k] && (cnt[k] == CNT_MAX);
    end
    // The limit is checked against the post-update cycle count, so a lowered
    // limit that is already exceeded ends the run on the next counted edge.
    cycle_new = cnt[0] + CNT_W'(inc[0]);
    limit_hit = (limit_i != '0) && (CMP_W'(cycle_new) >= CMP_W'(limit_i));
  end

  always_comb begin
    state_nxt = state;
    if (clr_i) begin
      state_nxt = IDLE;
    end else if (count_en) begin
      state_nxt = limit_hit ? DONE : RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      sat_o   <= '0;
      rdata_o <= '0;
    end else begin
      state   <= state_nxt;
      rdata_o <= cnt[sel_i];
      if (clr_i) begin
        cnt   <= '0;
        sat_o <= '0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (inc[k]) begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end
        sat_o <= sat_o | sat_hit;
      end
    end
  end

  assign done_o  = (state == DONE);
  assign state_o = state;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: a 32-bit instance checked against a cycle model
// through a readout scoreboard, plus a 4-bit instance for saturation.
module tb_pipe_perf_monitor;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clr;
  logic        bubble;
  logic        jump;
  logic        branch;
  logic        flush1;
  logic        flush2;
  logic        retire;
  logic [15:0] limit;
  logic [1:0]  sel;
  logic [31:0] rdata;
  logic        done;
  logic [3:0]  sat;
  logic [1:0]  state;
  logic [3:0]  rdata4;
  logic        done4;
  logic [3:0]  sat4;
  logic [1:0]  state4;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] m_cnt[4];
  logic [1:0]  m_state;

  pipe_perf_monitor #(.CNT_W(32), .LIMIT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr),
    .bubble_i(bubble), .jump_i(jump), .branch_i(branch),
    .flush1_i(flush1), .flush2_i(flush2), .retire_i(retire),
    .limit_i(limit), .sel_i(sel),
    .rdata_o(rdata), .done_o(done), .sat_o(sat), .state_o(state)
  );

  pipe_perf_monitor #(.CNT_W(4), .LIMIT_W(16)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr),
    .bubble_i(bubble), .jump_i(jump), .branch_i(branch),
    .flush1_i(flush1), .flush2_i(flush2), .retire_i(retire),
    .limit_i(limit), .sel_i(sel),
    .rdata_o(rdata4), .done_o(done4), .sat_o(sat4), .state_o(state4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_cnt[k] = '0;
    m_state = S_IDLE;
    exp_q.delete();
  endtask

  // Driver + scoreboard: one clock edge with the current inputs.
  task automatic tick();
    logic [31:0] exp_rd;
    logic        ev[4];
    exp_q.push_back(m_cnt[sel]);
    ev[0] = 1'b1;
    ev[1] = bubble && !jump && !branch;
    ev[2] = flush1 || flush2;
    ev[3] = retire;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      m_state = S_IDLE;
    end else if (start && m_state != S_DONE) begin
      for (int k = 0; k < 4; k++)
        if (ev[k] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
      m_state = (limit != 0 && m_cnt[0] >= {16'd0, limit}) ? S_DONE : S_RUN;
    end
    @(posedge clk);
    #1;
    exp_rd = exp_q.pop_front();
    n_tests++;
    if (rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL sb_rdata sel=%0d got %0d exp %0d", sel, rdata, exp_rd);
    end
    n_tests++;
    if (done !== (m_state == S_DONE)) begin
      n_fail++;
      $display("FAIL sb_done got %b exp %b", done, (m_state == S_DONE));
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rdata !== 32'd0 || done !== 1'b0 || sat !== 4'd0 || state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state rdata=%0d done=%b sat=%b state=%0d exp 0/0/0/IDLE",
               rdata, done, sat, state);
    end
    n_tests++;
    if (rdata4 !== 4'd0 || sat4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state4 rdata=%0d sat=%b exp 0/0", rdata4, sat4);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    n_tests++;
    if (state !== S_IDLE) begin
      n_fail++;
      $display("FAIL idle_no_start state got %0d exp %0d", state, S_IDLE);
    end
  endtask

  task automatic test_limit();
    do_clear();
    limit = 16'd30;
    start = 1'b1;
    sel   = 2'd0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 29) begin
        n_tests++;
        if (done !== 1'b0 || state !== S_RUN) begin
          n_fail++;
          $display("FAIL limit_early done=%b state=%0d exp 0/RUN", done, state);
        end
      end
    end
    n_tests++;
    if (done !== 1'b1 || state !== S_DONE) begin
      n_fail++;
      $display("FAIL limit_done done=%b state=%0d exp 1/DONE", done, state);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (rdata !== 32'd30) begin
      n_fail++;
      $display("FAIL limit_frozen cycle got %0d exp 30", rdata);
    end
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      sel = 2'(k);
      tick();
      n_tests++;
      if (rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL limit_other sel=%0d got %0d exp 0", k, rdata);
      end
    end
    limit = 16'd0;
  endtask

  task automatic test_clr_priority();
    start = 1'b1;
    clr   = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    n_tests++;
    if (state !== S_IDLE || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_prio state=%0d done=%b exp IDLE/0", state, done);
    end
    sel = 2'd0;
    tick();
    n_tests++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_prio_cycle got %0d exp 0", rdata);
    end
  endtask

  task automatic test_stall();
    do_clear();
    start  = 1'b1;
    bubble = 1'b1;
    tick();
    jump = 1'b1;
    tick();
    jump = 1'b0;
    tick();
    branch = 1'b1;
    tick();
    branch = 1'b0;
    bubble = 1'b0;
    start  = 1'b0;
    sel    = 2'd1;
    tick();
    n_tests++;
    if (rdata !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_count got %0d exp 2", rdata);
    end
  endtask

  task automatic test_flush();
    do_clear();
    start  = 1'b1;
    flush1 = 1'b1;
    flush2 = 1'b1;
    tick();
    flush1 = 1'b0;
    tick();
    flush2 = 1'b0;
    tick();
    start = 1'b0;
    sel   = 2'd2;
    tick();
    n_tests++;
    if (rdata !== 32'd2) begin
      n_fail++;
      $display("FAIL flush_count got %0d exp 2", rdata);
    end
  endtask

  task automatic test_hold();
    do_clear();
    sel = 2'd0;
    for (int i = 0; i < 20; i++) begin
      start  = !(i >= 5 && i < 10);
      retire = 1'($urandom_range(0, 1));
      tick();
      if (i >= 5 && i <= 10) begin
        n_tests++;
        if (rdata !== 32'd5) begin
          n_fail++;
          $display("FAIL hold_cycle i=%0d got %0d exp 5", i, rdata);
        end
      end
    end
    start  = 1'b0;
    retire = 1'b0;
    tick();
    n_tests++;
    if (rdata !== 32'd15 || state !== S_RUN) begin
      n_fail++;
      $display("FAIL hold_total cycle=%0d state=%0d exp 15/RUN", rdata, state);
    end
  endtask

  task automatic test_limit_change();
    do_clear();
    start = 1'b1;
    repeat (10) tick();
    limit = 16'd4;
    start = 1'b0;
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL lim_change_idle done got %b exp 0", done);
    end
    start = 1'b1;
    tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL lim_change_done done got %b exp 1", done);
    end
    start = 1'b0;
    sel   = 2'd0;
    tick();
    n_tests++;
    if (rdata !== 32'd11) begin
      n_fail++;
      $display("FAIL lim_change_cycle got %0d exp 11", rdata);
    end
    limit = 16'd0;
  endtask

  task automatic test_saturation();
    do_clear();
    start  = 1'b1;
    retire = 1'b1;
    repeat (20) tick();
    retire = 1'b0;
    start  = 1'b0;
    sel    = 2'd3;
    tick();
    n_tests++;
    if (rdata4 !== 4'd15 || sat4 !== 4'b1001) begin
      n_fail++;
      $display("FAIL sat_ret ret=%0d sat=%b exp 15/1001", rdata4, sat4);
    end
    n_tests++;
    if (rdata !== 32'd20 || sat !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_wide ret=%0d sat=%b exp 20/0000", rdata, sat);
    end
    do_clear();
    n_tests++;
    if (sat4 !== 4'd0 || state4 !== S_IDLE || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clr sat=%b state=%0d done=%b exp 0/IDLE/0", sat4, state4, done4);
    end
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      n_tests++;
      if (rdata4 !== 4'd0) begin
        n_fail++;
        $display("FAIL sat_clr_cnt sel=%0d got %0d exp 0", k, rdata4);
      end
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    start = 1'b1;
    sel   = 2'd0;
    repeat (7) tick();
    n_tests++;
    if (rdata !== 32'd6) begin
      n_fail++;
      $display("FAIL arst_pre got %0d exp 6", rdata);
    end
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (rdata !== 32'd0 || done !== 1'b0 || state !== S_IDLE) begin
      n_fail++;
      $display("FAIL arst_clear rdata=%0d done=%b state=%0d exp 0/0/IDLE", rdata, done, state);
    end
    start = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (state !== S_IDLE) begin
      n_fail++;
      $display("FAIL arst_wait state got %0d exp IDLE", state);
    end
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
    n_tests++;
    if (rdata !== 32'd3) begin
      n_fail++;
      $display("FAIL arst_restart cycle got %0d exp 3", rdata);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
    bubble  = 1'b0;
    jump    = 1'b0;
    branch  = 1'b0;
    flush1  = 1'b0;
    flush2  = 1'b0;
    retire  = 1'b0;
    limit   = 16'd0;
    sel     = 2'd0;
    model_reset();

    test_reset();
    test_limit();
    test_clr_priority();
    test_stall();
    test_flush();
    test_hold();
    test_limit_change();
    test_saturation();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
